// File: rtl/csr_access_unit_pkg.sv
// Shared widths, CSR addresses, Zicsr funct3 codes and helpers for the CSR access unit.
package csr_access_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned F3_W   = 3;

    localparam logic [CSR_AW-1:0] CSR_ALUCSR    = 12'h7C0;
    localparam logic [CSR_AW-1:0] CSR_MULCSR    = 12'h7C1;
    localparam logic [CSR_AW-1:0] CSR_DIVCSR    = 12'h7C2;
    localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_AW-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_AW-1:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [F3_W-1:0] F3_CSRRW  = 3'b001;
    localparam logic [F3_W-1:0] F3_CSRRS  = 3'b010;
    localparam logic [F3_W-1:0] F3_CSRRC  = 3'b011;
    localparam logic [F3_W-1:0] F3_CSRRWI = 3'b101;
    localparam logic [F3_W-1:0] F3_CSRRSI = 3'b110;
    localparam logic [F3_W-1:0] F3_CSRRCI = 3'b111;

    // Operation latched at accept; operand already resolved (rs1 data or zimm).
    typedef struct packed {
        logic [F3_W-1:0]   funct3;
        logic [CSR_AW-1:0] csr_index;
        logic [XLEN-1:0]   operand;
        logic              need_write;
    } csr_op_t;

    function automatic logic csr_is_counter(input logic [CSR_AW-1:0] idx);
        return (idx == CSR_MCYCLE)   || (idx == CSR_MCYCLEH) ||
               (idx == CSR_MINSTRET) || (idx == CSR_MINSTRETH);
    endfunction

    function automatic logic csr_is_known(input logic [CSR_AW-1:0] idx);
        return (idx == CSR_ALUCSR) || (idx == CSR_MULCSR) ||
               (idx == CSR_DIVCSR) || csr_is_counter(idx);
    endfunction

    function automatic logic f3_is_rw(input logic [F3_W-1:0] f3);
        return f3[1:0] == F3_CSRRW[1:0];
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshake between the execute stage (master) and the CSR access unit (slave).
interface csr_access_unit_if;
    import csr_access_unit_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [F3_W-1:0]   req_funct3;
    logic [CSR_AW-1:0] req_csr_index;
    logic [REG_AW-1:0] req_rs1_index;
    logic [REG_AW-1:0] req_rd_index;
    logic [XLEN-1:0]   req_rs1_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rd_data;
    logic              resp_illegal;

    modport master (
        output req_valid, req_funct3, req_csr_index, req_rs1_index, req_rd_index, req_rs1_data,
        output resp_ready,
        input  req_ready, resp_valid, resp_rd_data, resp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_csr_index, req_rs1_index, req_rd_index, req_rs1_data,
        input  resp_ready,
        output req_ready, resp_valid, resp_rd_data, resp_illegal
    );

endinterface

// File: rtl/csr_modify_logic.sv
// Combinational CSR update: new value from funct3, old CSR value and operand.
module csr_modify_logic
    import csr_access_unit_pkg::*;
(
    input  logic [F3_W-1:0] funct3,
    input  logic [XLEN-1:0] old_value,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] new_value_c
);

    always_comb begin
        new_value_c = old_value;
        unique case (funct3)
            F3_CSRRW, F3_CSRRWI: new_value_c = operand;
            F3_CSRRS, F3_CSRRSI: new_value_c = old_value | operand;
            F3_CSRRC, F3_CSRRCI: new_value_c = old_value & ~operand;
            default:             new_value_c = old_value;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr initiator: sequences one read and/or one write to the CSR file per accepted
// request and returns the old CSR value through a valid/ready response.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter bit CHECK_ACCESS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    csr_access_unit_if.slave  bus,
    output logic              read_enable_csr,
    output logic [CSR_AW-1:0] csr_read_index,
    input  logic [XLEN-1:0]   csr_read_data,
    output logic              write_enable_csr,
    output logic [CSR_AW-1:0] csr_write_index,
    output logic [XLEN-1:0]   csr_write_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    csr_op_t           op_q, op_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_illegal_q, resp_illegal_d;
    logic [XLEN-1:0]   resp_rd_data_q, resp_rd_data_d;
    logic              rd_en_q, rd_en_d;
    logic [CSR_AW-1:0] rd_idx_q, rd_idx_d;
    logic              wr_en_q, wr_en_d;
    logic [CSR_AW-1:0] wr_idx_q, wr_idx_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;

    csr_op_t           req_op_c;
    logic              accept_c;
    logic              req_need_read_c;
    logic              req_illegal_c;
    logic              illegal_c;
    logic [F3_W-1:0]   mod_funct3_c;
    logic [XLEN-1:0]   mod_old_c;
    logic [XLEN-1:0]   mod_operand_c;
    logic [XLEN-1:0]   new_value_c;

    // Decode of the presented request; only consumed on an IDLE handshake.
    always_comb begin
        req_op_c.funct3     = bus.req_funct3;
        req_op_c.csr_index  = bus.req_csr_index;
        req_op_c.operand    = bus.req_funct3[2] ? XLEN'(bus.req_rs1_index) : bus.req_rs1_data;
        req_op_c.need_write = f3_is_rw(bus.req_funct3) || (bus.req_rs1_index != '0);
        req_need_read_c     = !(f3_is_rw(bus.req_funct3) && (bus.req_rd_index == '0));
        req_illegal_c       = CHECK_ACCESS &&
                              (!csr_is_known(bus.req_csr_index) ||
                               (req_op_c.need_write && csr_is_counter(bus.req_csr_index)));
        accept_c            = bus.req_valid && req_ready_q;
    end

    // Write data is formed on the way into WRITE: from READ with the file data, from IDLE with old=0.
    always_comb begin
        if (state_q == ST_READ) begin
            mod_funct3_c  = op_q.funct3;
            mod_old_c     = csr_read_data;
            mod_operand_c = op_q.operand;
        end else begin
            mod_funct3_c  = bus.req_funct3;
            mod_old_c     = '0;
            mod_operand_c = req_op_c.operand;
        end
    end

    csr_modify_logic u_modify (
        .funct3      (mod_funct3_c),
        .old_value   (mod_old_c),
        .operand     (mod_operand_c),
        .new_value_c (new_value_c)
    );

    // Next state and next (registered) outputs, all derived from state_d.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        old_d     = old_q;
        illegal_c = resp_illegal_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d      = req_op_c;
                    old_d     = '0;
                    illegal_c = req_illegal_c;
                    if (req_illegal_c)        state_d = ST_RESP;
                    else if (req_need_read_c) state_d = ST_READ;
                    else                      state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                old_d   = csr_read_data;
                state_d = op_q.need_write ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d    = (state_d == ST_IDLE);
        resp_valid_d   = (state_d == ST_RESP);
        resp_illegal_d = (state_d == ST_RESP) && illegal_c;
        resp_rd_data_d = (state_d == ST_RESP) ? old_d : '0;
        rd_en_d        = (state_d == ST_READ);
        rd_idx_d       = rd_en_d ? op_d.csr_index : '0;
        wr_en_d        = (state_d == ST_WRITE);
        wr_idx_d       = wr_en_d ? op_d.csr_index : '0;
        wr_data_d      = wr_en_d ? new_value_c : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            old_q          <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_rd_data_q <= '0;
            rd_en_q        <= 1'b0;
            rd_idx_q       <= '0;
            wr_en_q        <= 1'b0;
            wr_idx_q       <= '0;
            wr_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            old_q          <= old_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_illegal_q <= resp_illegal_d;
            resp_rd_data_q <= resp_rd_data_d;
            rd_en_q        <= rd_en_d;
            rd_idx_q       <= rd_idx_d;
            wr_en_q        <= wr_en_d;
            wr_idx_q       <= wr_idx_d;
            wr_data_q      <= wr_data_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_illegal  = resp_illegal_q;
    assign bus.resp_rd_data  = resp_rd_data_q;
    assign read_enable_csr   = rd_en_q;
    assign csr_read_index    = rd_idx_q;
    assign write_enable_csr  = wr_en_q;
    assign csr_write_index   = wr_idx_q;
    assign csr_write_data    = wr_data_q;

endmodule
